// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 3-stage D/X/W RISC-V pipeline.
// Tracks the instructions in X and W and drives stall, squash, bubble and
// operand forwarding selects for the datapath.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [4:0]       d_rd,
  input  logic             d_reg_wen,
  input  logic             d_is_load,
  input  logic             x_redirect,
  input  logic             mem_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             kill_d,
  output logic             bubble_x,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam logic [2:0]       FLUSH_LEN = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state_q, state_d;
  logic [2:0] flush_q, flush_d;

  // Scoreboard of the instructions currently in X and W
  logic       x_v, x_wen, x_ld;
  logic [4:0] x_rd;
  logic       w_v, w_wen;
  logic [4:0] w_rd;

  logic luh;

  // X result is usable unless it is a load (data not back yet); W always is; x0 never
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       xv, input logic xwen, input logic xld, input logic [4:0] xrd,
    input logic       wv, input logic wwen, input logic [4:0] wrd
  );
    if (xv && xwen && !xld && (xrd != 5'd0) && (rs == xrd))
      return 2'b01;
    else if (wv && wwen && (wrd != 5'd0) && (rs == wrd))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign luh = x_v && x_ld && x_wen && (x_rd != 5'd0) && d_valid &&
               ((d_use_rs1 && (d_rs1 == x_rd)) || (d_use_rs2 && (d_rs2 == x_rd)));

  assign fwd_a = fwd_sel(d_rs1, x_v, x_wen, x_ld, x_rd, w_v, w_wen, w_rd);
  assign fwd_b = fwd_sel(d_rs2, x_v, x_wen, x_ld, x_rd, w_v, w_wen, w_rd);
  assign state = state_q;

  // Prioritised control decode: memory freeze, redirect, flush tail, load-use
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    kill_d   = 1'b0;
    bubble_x = 1'b0;
    state_d  = RUN;
    flush_d  = flush_q;
    if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      state_d = MEM_WAIT;
    end else if (x_redirect && x_v) begin
      kill_d   = 1'b1;
      bubble_x = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        flush_d = FLUSH_LEN;
        state_d = FLUSH;
      end
    end else if (state_q == FLUSH) begin
      kill_d   = 1'b1;
      bubble_x = 1'b1;
      flush_d  = flush_q - 3'd1;
      state_d  = (flush_q <= 3'd1) ? RUN : FLUSH;
    end else if (luh) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_x = 1'b1;
      state_d  = LOAD_STALL;
    end
  end

  // State, flush counter and scoreboard; the scoreboard freezes with the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flush_q <= 3'd0;
      x_v     <= 1'b0;
      x_rd    <= 5'd0;
      x_wen   <= 1'b0;
      x_ld    <= 1'b0;
      w_v     <= 1'b0;
      w_rd    <= 5'd0;
      w_wen   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (!mem_busy) begin
        w_v   <= x_v;
        w_rd  <= x_rd;
        w_wen <= x_wen;
        x_v   <= d_valid && !kill_d && !bubble_x;
        x_rd  <= d_rd;
        x_wen <= d_reg_wen;
        x_ld  <= d_is_load;
      end
    end
  end

  // Saturating performance counters for stall and squash cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (kill_d && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed pipeline scenarios followed
// by random traffic, compared cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int FC   = 1;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_valid = 1'b0;
  logic [4:0]    d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic          d_use_rs1 = 1'b0, d_use_rs2 = 1'b0;
  logic          d_reg_wen = 1'b0, d_is_load = 1'b0;
  logic          x_redirect = 1'b0, mem_busy = 1'b0;
  logic          stall_f, stall_d, kill_d, bubble_x;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd),
    .d_reg_wen(d_reg_wen), .d_is_load(d_is_load), .x_redirect(x_redirect),
    .mem_busy(mem_busy), .stall_f(stall_f), .stall_d(stall_d), .kill_d(kill_d),
    .bubble_x(bubble_x), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sf, sd, k, b, fa, fb, st, sc, fc;
  } exp_t;

  typedef struct {
    bit v; int rd; bit wen; bit ld;
  } slot_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;

  // Behavioural model: the instruction occupying each later stage, the number
  // of squash cycles still owed, the reported mode and the two event tallies
  slot_t in_x, in_w;
  int    owed_flush, mode, n_stall, n_kill;

  function automatic int src_of(int rs, slot_t sx, slot_t sw);
    if (sx.v && sx.wen && !sx.ld && sx.rd != 0 && rs == sx.rd) return 1;
    if (sw.v && sw.wen && sw.rd != 0 && rs == sw.rd) return 2;
    return 0;
  endfunction

  task automatic modelReset();
    in_x = '{0, 0, 0, 0};
    in_w = '{0, 0, 0, 0};
    owed_flush = 0; mode = 0; n_stall = 0; n_kill = 0;
  endtask

  task automatic checkOutput(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of D-stage inputs, predict the response, advance the model
  task automatic applyStimulus(bit dv, int rs1, int rs2, bit u1, bit u2, int rd,
                               bit wen, bit ld, bit redir, bit busy);
    exp_t e;
    bit   hazard;
    int   nxt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    d_valid = dv; d_rs1 = 5'(rs1); d_rs2 = 5'(rs2); d_use_rs1 = u1; d_use_rs2 = u2;
    d_rd = 5'(rd); d_reg_wen = wen; d_is_load = ld; x_redirect = redir; mem_busy = busy;
    e = '{0, 0, 0, 0, 0, 0, mode, n_stall, n_kill};
    e.fa = src_of(rs1, in_x, in_w);
    e.fb = src_of(rs2, in_x, in_w);
    hazard = in_x.v && in_x.ld && in_x.wen && in_x.rd != 0 && dv &&
             ((u1 && rs1 == in_x.rd) || (u2 && rs2 == in_x.rd));
    if (busy) begin
      e.sf = 1; e.sd = 1; nxt = 2;
    end else if (redir && in_x.v) begin
      e.k = 1; e.b = 1;
      owed_flush = FC;
      nxt = (FC > 0) ? 3 : 0;
    end else if (mode == 3) begin
      e.k = 1; e.b = 1;
      owed_flush = owed_flush - 1;
      nxt = (owed_flush == 0) ? 0 : 3;
    end else if (hazard) begin
      e.sf = 1; e.sd = 1; e.b = 1; nxt = 1;
    end else begin
      nxt = 0;
    end
    exp_q.push_back(e);
    if (e.sd == 1) n_stall = (n_stall == CMAX) ? CMAX : n_stall + 1;
    if (e.k == 1)  n_kill  = (n_kill == CMAX) ? CMAX : n_kill + 1;
    if (!busy) begin
      in_w = in_x;
      in_x = '{dv && e.k == 0 && e.b == 0, rd, wen, ld};
    end
    mode = nxt;
  endtask

  // Pull reset low just after an edge; everything must clear before the next one
  task automatic applyReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    d_valid = 0; d_use_rs1 = 0; d_use_rs2 = 0; d_reg_wen = 0; d_is_load = 0;
    d_rs1 = '0; d_rs2 = '0; d_rd = '0; x_redirect = 0; mem_busy = 0;
    modelReset();
    exp_q.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("stall_f", int'(stall_f), e.sf);
        checkOutput("stall_d", int'(stall_d), e.sd);
        checkOutput("kill_d", int'(kill_d), e.k);
        checkOutput("bubble_x", int'(bubble_x), e.b);
        checkOutput("fwd_a", int'(fwd_a), e.fa);
        checkOutput("fwd_b", int'(fwd_b), e.fb);
        checkOutput("state", int'(state), e.st);
        checkOutput("stall_cnt", int'(stall_cnt), e.sc);
        checkOutput("flush_cnt", int'(flush_cnt), e.fc);
      end
    end
  end

  // Directed pipeline scenarios, then randomised traffic with held memory stalls
  initial begin
    int busy_left;
    bit dv, u1, u2, wen, ld, redir;
    int rs1, rs2, rd;
    modelReset();
    applyReset();
    // add x5, then a reader of x5 (X forward), which is lw x6
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    applyStimulus(1, 5, 0, 1, 0, 6, 1, 1, 0, 0);
    // consumer of x6 right behind the load: one stall, then W forward
    applyStimulus(1, 1, 6, 1, 1, 7, 1, 0, 0, 0);
    applyStimulus(1, 1, 6, 1, 1, 7, 1, 0, 0, 0);
    // redirect resolved in X, then the flush tail
    applyStimulus(1, 7, 7, 1, 1, 8, 1, 0, 1, 0);
    applyStimulus(1, 8, 7, 1, 1, 9, 1, 0, 0, 0);
    applyStimulus(1, 8, 9, 1, 1, 3, 1, 0, 0, 0);
    // redirect held under three cycles of memory busy
    applyStimulus(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4, 3, 1, 1, 2, 1, 0, 1, 1);
    applyStimulus(1, 4, 3, 1, 1, 2, 1, 0, 1, 0);
    applyStimulus(1, 4, 3, 1, 1, 2, 1, 0, 0, 0);
    // lw x0 must never stall or forward; x7 in both X and W prefers X
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    applyStimulus(1, 7, 7, 1, 1, 1, 0, 0, 0, 0);
    // reset in the middle of a flush
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 0, 1, 0);
    applyReset();
    // random traffic; D and redirect inputs stay frozen while memory is busy
    busy_left = 0;
    dv = 0; u1 = 0; u2 = 0; wen = 0; ld = 0; redir = 0; rs1 = 0; rs2 = 0; rd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (busy_left > 0) begin
        busy_left--;
        applyStimulus(dv, rs1, rs2, u1, u2, rd, wen, ld, redir, 1);
      end else if ($urandom_range(0, 599) == 0) begin
        applyReset();
      end else begin
        dv = ($urandom_range(0, 9) != 0);
        rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
        ld = ($urandom_range(0, 2) == 0);
        wen = ld ? 1'b1 : 1'($urandom_range(0, 1));
        redir = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 14) == 0) begin
          busy_left = $urandom_range(0, 3);
          applyStimulus(dv, rs1, rs2, u1, u2, rd, wen, ld, redir, 1);
        end else begin
          applyStimulus(dv, rs1, rs2, u1, u2, rd, wen, ld, redir, 0);
        end
      end
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
